// File: rtl/mix_columns_seq_pkg.sv
// rtl/mix_columns_seq_pkg.sv - shared AES widths, GF(2^8) helpers and FSM state type
package mix_columns_seq_pkg;

  localparam int COL_W    = 32;
  localparam int BYTE_W   = 8;
  localparam int STATE_W  = 128;
  localparam int NUM_COLS = 4;

  localparam logic [BYTE_W-1:0] GF_RED = 8'h1b;

  typedef enum logic {IDLE, BUSY} state_t;

  function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] x);
    return {x[BYTE_W-2:0], 1'b0} ^ (x[BYTE_W-1] ? GF_RED : 8'h00);
  endfunction

endpackage

// File: rtl/mix_columns_seq_single_column.sv
// rtl/mix_columns_seq_single_column.sv - combinational MixColumns of one 32-bit column
module mix_single_column
  import mix_columns_seq_pkg::*;
(
  input  logic [COL_W-1:0] col_in,
  output logic [COL_W-1:0] col_out
);

  logic [BYTE_W-1:0] a0, a1, a2, a3;
  logic [BYTE_W-1:0] x0, x1, x2, x3;

  assign a0 = col_in[0*BYTE_W +: BYTE_W];
  assign a1 = col_in[1*BYTE_W +: BYTE_W];
  assign a2 = col_in[2*BYTE_W +: BYTE_W];
  assign a3 = col_in[3*BYTE_W +: BYTE_W];

  assign x0 = xtime(a0);
  assign x1 = xtime(a1);
  assign x2 = xtime(a2);
  assign x3 = xtime(a3);

  // 3*a is expanded as xtime(a) ^ a
  assign col_out[0*BYTE_W +: BYTE_W] = x0 ^ (x1 ^ a1) ^ a2 ^ a3;
  assign col_out[1*BYTE_W +: BYTE_W] = a0 ^ x1 ^ (x2 ^ a2) ^ a3;
  assign col_out[2*BYTE_W +: BYTE_W] = a0 ^ a1 ^ x2 ^ (x3 ^ a3);
  assign col_out[3*BYTE_W +: BYTE_W] = (x0 ^ a0) ^ a1 ^ a2 ^ x3;

endmodule

// File: rtl/mix_columns_seq.sv
// rtl/mix_columns_seq.sv - sequential forward MixColumns, COLS_PER_CYCLE columns per falling edge
module mix_columns_seq
  import mix_columns_seq_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [STATE_W-1:0] value,
  output logic [STATE_W-1:0] outValue,
  output logic               busy,
  output logic               success
);

  state_t             state;
  logic [1:0]         counter;
  logic [STATE_W-1:0] work;
  logic [STATE_W-1:0] work_next;
  logic               last;

  logic [1:0]       col_idx [COLS_PER_CYCLE];
  logic [COL_W-1:0] col_in  [COLS_PER_CYCLE];
  logic [COL_W-1:0] col_out [COLS_PER_CYCLE];

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    assign col_idx[g] = counter + 2'(g);
    assign col_in[g]  = work[col_idx[g]*COL_W +: COL_W];
    mix_single_column u_col (
      .col_in  (col_in[g]),
      .col_out (col_out[g])
    );
  end

  always_comb begin
    work_next = work;
    for (int g = 0; g < COLS_PER_CYCLE; g++) begin
      work_next[col_idx[g]*COL_W +: COL_W] = col_out[g];
    end
  end

  // Widened to 3 bits so the final column group is detected before the 2-bit counter wraps
  assign last = (({1'b0, counter} + 3'(COLS_PER_CYCLE)) == 3'(NUM_COLS));

  always_ff @(negedge clk) begin
    if (reset) begin
      state    <= IDLE;
      counter  <= 2'd0;
      work     <= '0;
      outValue <= '0;
      busy     <= 1'b0;
      success  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          success <= 1'b0;
          if (enable) begin
            work    <= value;
            counter <= 2'd0;
            busy    <= 1'b1;
            state   <= BUSY;
          end
        end
        BUSY: begin
          work <= work_next;
          if (last) begin
            outValue <= work_next;
            success  <= 1'b1;
            busy     <= 1'b0;
            counter  <= 2'd0;
            state    <= IDLE;
          end else begin
            counter <= counter + 2'(COLS_PER_CYCLE);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
